// File: rtl/fb_lcd_scanout_pkg.sv
// Shared definitions for the LCD frame-buffer scanout: scan FSM states,
// frame-buffer geometry and pixel/palette helpers.
package fb_lcd_scanout_pkg;

  localparam int          FB_WORDS     = 8192;
  localparam int          FB_ROW_WORDS = 32;
  localparam logic [12:0] FB_LAST_ADDR = 13'd8191;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_STREAM
  } scanState_t;

  // Pixel at column offset sub within a packed word; [15:14] is the leftmost.
  function automatic logic [1:0] pixelOf(input logic [15:0] word, input logic [2:0] sub);
    return word[{~sub, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] shadeOf(input logic [7:0] bgp, input logic [1:0] raw);
    return bgp[{raw, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/fb_lcd_scanout_if.sv
// Pixel stream from the frame-buffer scanout to the LCD board (valid/ready).
interface fb_lcd_scanout_if;

  logic       oPixelValid;
  logic [1:0] oPixel;
  logic       oLineEnd;
  logic       oFrameEnd;
  logic       iPixelReady;

  modport master (
    output oPixelValid,
    output oPixel,
    output oLineEnd,
    output oFrameEnd,
    input  iPixelReady
  );

  modport slave (
    input  oPixelValid,
    input  oPixel,
    input  oLineEnd,
    input  oFrameEnd,
    output iPixelReady
  );

endinterface

// File: rtl/fb_lcd_scanout_dp_ram.sv
// 8192x16 frame-buffer bank: one write port, one registered read port, read-first.
module fb_dp_ram
  import fb_lcd_scanout_pkg::*;
(
  input  logic        iClock,
  input  logic        iWe,
  input  logic [12:0] iWrAddr,
  input  logic [15:0] iWrData,
  input  logic [12:0] iRdAddr,
  output logic [15:0] oRdData
);

  logic [15:0] mem [FB_WORDS];

  always_ff @(posedge iClock) begin
    if (iWe) begin
      mem[iWrAddr] <= iWrData;
    end
    oRdData <= mem[iRdAddr];
  end

endmodule

// File: rtl/fb_lcd_scanout.sv
// Frame-buffer store and scrolled 160x144 palette-mapped scanout for the LCD.
// FB_DOUBLE_BUFFER_EN selects two banks with a tear-free swap at frame start.
module fb_lcd_scanout
  import fb_lcd_scanout_pkg::*;
#(
  parameter int VIS_W = 160,
  parameter int VIS_H = 144
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iFrameBufferWe,
  input  logic [15:0]              iFrameBufferData,
  input  logic [15:0]              iFrameBufferAddr,
  input  logic [7:0]               iSCX,
  input  logic [7:0]               iSCY,
  input  logic [7:0]               iBGP,
  fb_lcd_scanout_if.master         pixelBus,
  output logic                     oBusy,
  output logic                     oFrontBank
);

  localparam logic [7:0] X_LAST = 8'(VIS_W - 1);
  localparam logic [7:0] Y_LAST = 8'(VIS_H - 1);

  scanState_t  state, stateNext;
  logic [7:0]  x, y;
  logic [7:0]  scx, scy, bgp;
  logic [15:0] word;
  logic        pending;
  logic [15:0] rdData;
  logic [7:0]  col, row;
  logic [12:0] rdAddr;
  logic        trigger, handshake, pixelValid;
  logic        lineLast, frameLast, startFrame;
  logic        unusedAddrHigh;

  assign unusedAddrHigh = ^iFrameBufferAddr[15:13];

  assign trigger    = iFrameBufferWe && (iFrameBufferAddr[12:0] == FB_LAST_ADDR);
  assign pixelValid = (state == ST_STREAM);
  assign handshake  = pixelValid && pixelBus.iPixelReady;
  assign lineLast   = (x == X_LAST);
  assign frameLast  = lineLast && (y == Y_LAST);

  assign col    = scx + x;
  assign row    = scy + y;
  assign rdAddr = {row, col[7:3]};

`ifdef FB_DOUBLE_BUFFER_EN
  logic        frontBank;
  logic [15:0] rdData0, rdData1;

  // GPU always writes the back bank; the swap happens on the frame-start edge.
  fb_dp_ram bank0 (
    .iClock  (iClock),
    .iWe     (iFrameBufferWe && frontBank),
    .iWrAddr (iFrameBufferAddr[12:0]),
    .iWrData (iFrameBufferData),
    .iRdAddr (rdAddr),
    .oRdData (rdData0)
  );

  fb_dp_ram bank1 (
    .iClock  (iClock),
    .iWe     (iFrameBufferWe && !frontBank),
    .iWrAddr (iFrameBufferAddr[12:0]),
    .iWrData (iFrameBufferData),
    .iRdAddr (rdAddr),
    .oRdData (rdData1)
  );

  assign rdData = frontBank ? rdData1 : rdData0;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      frontBank <= 1'b0;
    end else if (startFrame) begin
      frontBank <= ~frontBank;
    end
  end

  assign oFrontBank = frontBank;
`else
  fb_dp_ram bank0 (
    .iClock  (iClock),
    .iWe     (iFrameBufferWe),
    .iWrAddr (iFrameBufferAddr[12:0]),
    .iWrData (iFrameBufferData),
    .iRdAddr (rdAddr),
    .oRdData (rdData)
  );

  assign oFrontBank = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A trigger landing on the frame-end handshake counts as pending.
  always_comb begin
    stateNext  = state;
    startFrame = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trigger) begin
          stateNext  = ST_FETCH;
          startFrame = 1'b1;
        end
      end
      ST_FETCH:  stateNext = ST_LOAD;
      ST_LOAD:   stateNext = ST_STREAM;
      ST_STREAM: begin
        if (handshake) begin
          if (frameLast) begin
            if (pending || trigger) begin
              stateNext  = ST_FETCH;
              startFrame = 1'b1;
            end else begin
              stateNext = ST_IDLE;
            end
          end else if (lineLast || (col[2:0] == 3'd7)) begin
            stateNext = ST_FETCH;
          end
        end
      end
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      x       <= '0;
      y       <= '0;
      scx     <= '0;
      scy     <= '0;
      bgp     <= '0;
      word    <= '0;
      pending <= 1'b0;
    end else begin
      if (startFrame) begin
        scx     <= iSCX;
        scy     <= iSCY;
        bgp     <= iBGP;
        x       <= '0;
        y       <= '0;
        pending <= 1'b0;
      end else begin
        if (trigger && (state != ST_IDLE)) begin
          pending <= 1'b1;
        end
        if (handshake) begin
          if (lineLast) begin
            x <= '0;
            y <= y + 8'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
      end
      if (state == ST_LOAD) begin
        word <= rdData;
      end
    end
  end

  // Outputs derive only from registers that move on a handshake, so they hold while stalled.
  assign pixelBus.oPixelValid = pixelValid;
  assign pixelBus.oPixel      = pixelValid ? shadeOf(bgp, pixelOf(word, col[2:0])) : 2'b00;
  assign pixelBus.oLineEnd    = pixelValid && lineLast;
  assign pixelBus.oFrameEnd   = pixelValid && frameLast;
  assign oBusy                = (state != ST_IDLE);

endmodule
